wb_mem: RTL and testbench
=========================

# wb_mem

Pipelined WISHBONE (B4, pipelined mode) memory slave. It serves the instruction-fetch bus of the CPU: it accepts one request per cycle and returns data with a fixed latency. It can optionally inject pseudo-random stalls so that the upstream master's stall handling is exercised in simulation and formal runs. Writes are supported so that the same block can back a unified instruction/data memory.

## Interface
Parameters:
- G_ADDR_SIZE, 8 — memory depth is 2**G_ADDR_SIZE words
- G_DATA_SIZE, 16 — word width
- G_LATENCY, 2 — cycles from acceptance to ack; legal range 1..4
- G_STALL_EN, false — enable LFSR stall injection

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe
- wb_stall_o  out  1  slave cannot accept a request this cycle
- wb_addr_i  in  16  word address
- wb_we_i  in  1  1 = write, 0 = read
- wb_dat_i  in  G_DATA_SIZE  write data
- wb_ack_o  out  1  response valid, one cycle per request
- wb_data_o  out  G_DATA_SIZE  read data, valid when wb_ack_o = 1

## Operation
- Acceptance: a request is accepted at a rising edge when wb_cyc_i, wb_stb_i and not wb_stall_o are all high.
- Addressing: only wb_addr_i[G_ADDR_SIZE-1:0] is used. Upper bits are ignored, so addresses wrap.
- Write: the memory is updated at the acceptance edge. The write is acked like a read, and wb_data_o = 0 on that ack.
- Read: the word is sampled at the acceptance edge. A read accepted one cycle after a write to the same address returns the new data.
- Read/write in the same cycle is impossible, since there is one request per edge.
- Response pipeline: shift register of G_LATENCY stages, each holding {valid, data}. Stage 0 is loaded at acceptance. wb_ack_o and wb_data_o are driven from the last stage.
- Ordering: responses are strictly in order.
- Throughput: 1 request per cycle when not stalled.
- Abort: if wb_cyc_i = 0 in a cycle, every pipeline valid bit is cleared at the next edge. No acks are produced for requests issued before cyc was dropped.
- wb_ack_o is never high while wb_cyc_i has been low for ≥1 cycle.
- Stall, G_STALL_EN = false: wb_stall_o = 0 permanently.
- Stall, G_STALL_EN = true:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 advances on every edge when not in reset.
  - wb_stall_o = lfsr[0] and lfsr[1], giving roughly 25% stall.
  - The stall is registered and independent of wb_stb_i and wb_cyc_i.
- Memory contents are not reset and are uninitialised (X) in simulation. Benches must write before reading.

## Timing
- Reset values, held while rst_i = 1 and forced asynchronously:
  - wb_ack_o = 0
  - wb_data_o = 0
  - wb_stall_o = 0
  - all pipeline valid bits = 0
  - LFSR = 0xACE1
- The first possible acceptance is at the first edge after rst_i deasserts.
- Latency: a request accepted at edge N gives wb_ack_o = 1 in the cycle following edge N+G_LATENCY-1. For G_LATENCY=1, the ack is in the cycle directly after acceptance.
- Back-to-back requests at edges N and N+1 give acks in consecutive cycles.
- Stall and strobe in the same cycle: the request is not accepted. The master must hold it, and the slave applies no timeout.
- Reset mid-transfer: pending responses are lost and no ack is issued. The memory contents written before the reset are retained.
- Maximum outstanding requests is G_LATENCY. Stall is never asserted because of outstanding requests.

## Structure
- Package wb_mem_pkg:
  - C_LFSR_SEED = 0xACE1
  - C_LFSR_TAPS = 16#B400#
  - response-stage record type {valid, data}
- Sub-module lfsr16:
  - ports clk_i, rst_i, lfsr_o[15:0]
  - reset to the seed, advances every cycle
- Top level: memory array, response shift register and stall logic.

## Test plan
- Write 0x1234 to address 0x0005, then read 0x0005 with G_LATENCY=2 → one ack for the write (data 0), then an ack 2 cycles after the read is accepted with wb_data_o = 0x1234.
- Read addresses 0x0105 and 0x0005 back-to-back (G_ADDR_SIZE=8) → acks in consecutive cycles, both 0x1234 (wrap).
- Issue 4 consecutive reads of distinct preloaded words with G_LATENCY=4 → 4 acks in consecutive cycles, in order, with correct data.
- Issue 2 reads, then drop wb_cyc_i for 1 cycle before the acks are due → no ack is produced.
- G_STALL_EN=true, stb held high for 200 cycles → accepted count equals the number of non-stall cycles, acks equal accepts, and wb_stall_o matches a reference LFSR seeded 0xACE1.
- Assert rst_i asynchronously with 2 reads outstanding → wb_ack_o drops immediately, no acks after release, and earlier writes still read back correctly.

Source files
------------

// File: rtl/wb_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_mem_pkg: shared constants, response record and LFSR helper      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package wb_mem_pkg;

  localparam logic [15:0] C_LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] C_LFSR_TAPS     = 16'hB400;
  localparam int          C_MAX_DATA_SIZE = 64;

  // Upper data bits beyond the instance width stay zero and are trimmed away.
  typedef struct packed {
    logic                       valid;
    logic [C_MAX_DATA_SIZE-1:0] data;
  } resp_t;

  // Tap k of the right-shifting Fibonacci register feeds from state bit 16-k.
  function automatic logic lfsr_feedback(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (C_LFSR_TAPS[15-k]) fb = fb ^ s[k];
    end
    return fb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr16: free-running 16-bit Fibonacci LFSR, reset to the seed      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lfsr16
  import wb_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_feedback(lfsr_q), lfsr_q[15:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= C_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/wb_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_mem: pipelined WISHBONE memory slave, fixed-latency responses   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_mem
  import wb_mem_pkg::*;
#(
  parameter int G_ADDR_SIZE = 8,
  parameter int G_DATA_SIZE = 16,
  parameter int G_LATENCY   = 2,
  parameter bit G_STALL_EN  = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic                   wb_stall_o,
  input  logic [15:0]            wb_addr_i,
  input  logic                   wb_we_i,
  input  logic [G_DATA_SIZE-1:0] wb_dat_i,
  output logic                   wb_ack_o,
  output logic [G_DATA_SIZE-1:0] wb_data_o
);

  localparam int C_LAST = G_LATENCY - 1;

  logic [G_DATA_SIZE-1:0] mem_q [2**G_ADDR_SIZE];
  resp_t                  pipe_q [G_LATENCY];
  resp_t                  pipe_d [G_LATENCY];
  logic                   stall;
  logic                   accept;
  logic [G_ADDR_SIZE-1:0] addr;

  assign addr   = wb_addr_i[G_ADDR_SIZE-1:0];
  assign accept = wb_cyc_i & wb_stb_i & ~stall;

  generate
    if (G_STALL_EN) begin : g_stall
      logic [15:0] lfsr;
      logic        unused_lfsr;
      lfsr16 u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (lfsr)
      );
      assign stall       = lfsr[0] & lfsr[1];
      assign unused_lfsr = ^lfsr[15:2];
    end else begin : g_no_stall
      assign stall = 1'b0;
    end

    if (G_ADDR_SIZE < 16) begin : g_addr_wrap
      logic unused_addr;
      assign unused_addr = ^wb_addr_i[15:G_ADDR_SIZE];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && !rst_i) begin
      mem_q[addr] <= wb_dat_i;
    end
  end

  // Dropping cyc flushes everything in flight, so no stale ack leaks out.
  always_comb begin
    pipe_d[0]       = '0;
    pipe_d[0].valid = accept;
    if (accept && !wb_we_i) begin
      pipe_d[0].data[G_DATA_SIZE-1:0] = mem_q[addr];
    end
    for (int i = 1; i < G_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (!wb_cyc_i) pipe_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < G_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < G_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  logic unused_resp;
  assign unused_resp = ^pipe_q[C_LAST].data;

  assign wb_stall_o = stall;
  assign wb_ack_o   = pipe_q[C_LAST].valid;
  assign wb_data_o  = pipe_q[C_LAST].data[G_DATA_SIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_wb_mem.sv
`timescale 1ns/1ps
// Bench for wb_mem: three instances (latency 2, latency 4, latency 1 with
// stall injection) share one master stimulus and are checked against a model.
module tb_wb_mem;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we  = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdat = '0;
  logic [NI-1:0] ack;
  logic [NI-1:0] stall;
  logic [15:0] rdat [NI];

  always #5 clk = ~clk;

  wb_mem #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_LATENCY(2), .G_STALL_EN(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_stall_o(stall[0]),
    .wb_addr_i(addr), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[0]), .wb_data_o(rdat[0]));

  wb_mem #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_LATENCY(4), .G_STALL_EN(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_stall_o(stall[1]),
    .wb_addr_i(addr), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[1]), .wb_data_o(rdat[1]));

  wb_mem #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_LATENCY(1), .G_STALL_EN(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_stall_o(stall[2]),
    .wb_addr_i(addr), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[2]), .wb_data_o(rdat[2]));

  // Reference model: expected responses are kept as (instance, due cycle, data).
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
    bit          known;
  } exp_t;

  int          lat [NI] = '{2, 4, 1};
  exp_t        expq[$];
  logic [15:0] m_mem   [NI][256];
  bit          m_known [NI][256];
  logic [15:0] m_lfsr = 16'hACE1;
  int          t = 0;
  int          n_acc [NI];
  int          n_ack [NI];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic model_stall(input int i);
    return (i == 2) ? (m_lfsr[0] & m_lfsr[1]) : 1'b0;
  endfunction

  // Applies the acceptance rules for the edge about to happen.
  task automatic model_edge();
    int idx;
    exp_t e;
    t++;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (!cyc) begin
          for (int k = expq.size() - 1; k >= 0; k--)
            if (expq[k].inst == i) expq.delete(k);
        end else if (stb && !model_stall(i)) begin
          idx = int'(addr[7:0]);
          n_acc[i]++;
          e.inst = i;
          e.due  = t + lat[i] - 1;
          if (we) begin
            m_mem[i][idx]   = wdat;
            m_known[i][idx] = 1'b1;
            e.data  = 16'h0000;
            e.known = 1'b1;
          end else begin
            e.data  = m_mem[i][idx];
            e.known = m_known[i][idx];
          end
          expq.push_back(e);
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic check_outputs();
    bit          e_ack;
    bit          e_known;
    logic [15:0] e_dat;
    for (int i = 0; i < NI; i++) begin
      e_ack = 1'b0;
      e_known = 1'b0;
      e_dat = '0;
      for (int k = expq.size() - 1; k >= 0; k--) begin
        if (expq[k].inst == i && expq[k].due <= t) begin
          if (expq[k].due == t) begin
            e_ack   = 1'b1;
            e_dat   = expq[k].data;
            e_known = expq[k].known;
          end
          expq.delete(k);
        end
      end
      check_val($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(e_ack));
      if (e_ack && e_known) check_val($sformatf("data[%0d]", i), 32'(rdat[i]), 32'(e_dat));
      check_val($sformatf("stall[%0d]", i), 32'(stall[i]), 32'(model_stall(i)));
      if (ack[i]) n_ack[i]++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
    step();
  endtask

  task automatic idle(input int n);
    cyc = 1'b1; stb = 1'b0; we = 1'b0;
    repeat (n) step();
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  // Reset is raised mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    expq.delete();
    m_lfsr = 16'hACE1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("rst_ack[%0d]", i), 32'(ack[i]), 32'h0);
      check_val($sformatf("rst_data[%0d]", i), 32'(rdat[i]), 32'h0);
      check_val($sformatf("rst_stall[%0d]", i), 32'(stall[i]), 32'h0);
    end
    repeat (hold) step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap_acc [NI];
    int snap_ack [NI];

    async_reset(3);

    // Write then read back, and an aliased address pair.
    req(1'b1, 16'h0005, 16'h1234);
    req(1'b0, 16'h0005, 16'h0000);
    idle(6);
    req(1'b0, 16'h0105, 16'h0000);
    req(1'b0, 16'h0005, 16'h0000);
    idle(6);

    // Preload every word, using random upper address bits to exercise wrap.
    for (int a = 0; a < 256; a++)
      req(1'b1, {8'($urandom), 8'(a)}, 16'($urandom));
    idle(6);

    for (int k = 0; k < 4; k++) req(1'b0, 16'h0020 + 16'(k), 16'h0000);
    idle(6);

    // Abort with reads in flight.
    req(1'b0, 16'h0003, 16'h0000);
    req(1'b0, 16'h0004, 16'h0000);
    drop();
    idle(6);

    // Strobe held for 200 cycles: every accept must be acked exactly once.
    for (int i = 0; i < NI; i++) begin
      snap_acc[i] = n_acc[i];
      snap_ack[i] = n_ack[i];
    end
    repeat (200) req(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom));
    idle(6);
    for (int i = 0; i < NI; i++)
      check_val($sformatf("acks_vs_accepts[%0d]", i),
                32'(n_ack[i] - snap_ack[i]), 32'(n_acc[i] - snap_acc[i]));
    check_val("acks_no_stall", 32'(n_ack[0] - snap_ack[0]), 32'd200);

    // Fully random master behaviour, including cyc drops.
    repeat (300) begin
      cyc  = ($urandom_range(0, 9) != 0);
      stb  = ($urandom_range(0, 4) != 0);
      we   = ($urandom_range(0, 2) == 0);
      addr = 16'($urandom);
      wdat = 16'($urandom);
      step();
    end
    idle(6);

    // Reset with reads outstanding; memory must survive it.
    req(1'b1, 16'h0077, 16'hBEEF);
    req(1'b0, 16'h0040, 16'h0000);
    req(1'b0, 16'h0041, 16'h0000);
    async_reset(2);
    idle(3);
    req(1'b0, 16'h0077, 16'h0000);
    req(1'b0, 16'h0040, 16'h0000);
    req(1'b0, 16'h0041, 16'h0000);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
